hb_mac_sched: RTL and testbench

Sequencer for the time-shared half-band decimation filter in the ADC decimation chain. It splits the input sample stream into even/odd polyphase branches, maintains the write pointer of the 38-entry even-branch ring buffer, and, once per odd sample, drives a single shared multiply-accumulate unit through 19 symmetric tap pairs plus the centre tap. It flags the finished decimated output and reports overruns. It sits between the upstream filter's valid strobe and the hb MAC datapath, which owns the buffer RAM, the centre delay line, the coefficient ROM and the accumulator.

---
 rtl/hb_mac_sched_pkg.sv | 17 +
 rtl/hb_mac_sched_mod_addr.sv | 35 +++
 rtl/hb_mac_sched.sv | 169 ++++++++++++++++
 tb/tb_hb_mac_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hb_mac_sched_pkg.sv
// Shared constants and FSM encoding for the half-band MAC sequencer.
// This package is the shared definition set that the hb_defs.vh include would otherwise carry.
package hb_mac_sched_pkg;
   localparam int NPAIR   = 19;
   localparam int DEPTH   = 38;
   localparam int CTR_IDX = 19;
   localparam int ADDR_W  = 6;
   localparam int COEF_W  = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_CTR   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } hb_state_e;
endpackage

// File: rtl/hb_mac_sched_mod_addr.sv
// Ring-buffer address arithmetic: (base +/- off) mod DEPTH, for base < DEPTH and off <= DEPTH.
module hb_mod_addr
   import hb_mac_sched_pkg::*;
(
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] off,
   input  logic              sub,
   output logic [ADDR_W-1:0] res
);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0] base_x_s;
   logic [ADDR_W:0] off_x_s;
   logic [ADDR_W:0] sum_s;

   // A single conditional correction is enough because both operands stay below one ring length
   always_comb begin
      base_x_s = {1'b0, base};
      off_x_s  = {1'b0, off};
      sum_s    = base_x_s + off_x_s;
      if (sub) begin
         if (base_x_s >= off_x_s) begin
            res = ADDR_W'(base_x_s - off_x_s);
         end else begin
            res = ADDR_W'(base_x_s + DEPTH_X - off_x_s);
         end
      end else begin
         if (sum_s >= DEPTH_X) begin
            res = ADDR_W'(sum_s - DEPTH_X);
         end else begin
            res = ADDR_W'(sum_s);
         end
      end
   end
endmodule

// File: rtl/hb_mac_sched.sv
// Half-band decimator sequencer: polyphase split, even ring write pointer and
// per-odd-sample MAC step generation (19 symmetric pairs, centre tap, drain, done).
module hb_mac_sched
   import hb_mac_sched_pkg::*;
#(
   parameter int MAC_LAT = 2
)
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              sclr,
   input  logic              in_vld,
   input  logic              err_clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              ctr_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [COEF_W-1:0] coef_idx,
   output logic              mac_en,
   output logic              mac_clr,
   output logic              mac_sub,
   output logic              ctr_sel,
   output logic              out_vld,
   output logic              busy,
   output logic              ovf_err
);
   hb_state_e         state_r;
   logic              phase_r;
   logic [4:0]        k_r;
   logic [ADDR_W-1:0] wp_snap_r;

   logic              start_s;
   logic              run_busy_s;
   logic [4:0]        k_nxt_s;
   logic [ADDR_W-1:0] base_s;
   logic [ADDR_W-1:0] off_a_s;
   logic [ADDR_W-1:0] off_b_s;
   logic [ADDR_W-1:0] addr_a_s;
   logic [ADDR_W-1:0] addr_b_s;

   assign start_s    = in_vld & phase_r & ~sclr;
   assign wr_en      = in_vld & ~phase_r & ~sclr;
   assign ctr_en     = start_s;
   assign run_busy_s = (state_r == ST_RUN) || (state_r == ST_CTR) || (state_r == ST_DRAIN);

   // Addresses for the step issued next cycle; a new sequence reads around the live pointer
   always_comb begin
      if (state_r == ST_RUN) begin
         base_s  = wp_snap_r;
         k_nxt_s = k_r + 5'd1;
      end else begin
         base_s  = wr_addr;
         k_nxt_s = 5'd0;
      end
      off_b_s = ADDR_W'(k_nxt_s);
      off_a_s = ADDR_W'(k_nxt_s) + 6'd1;
   end

   hb_mod_addr u_addr_a (.base(base_s), .off(off_a_s), .sub(1'b1), .res(addr_a_s));
   hb_mod_addr u_addr_b (.base(base_s), .off(off_b_s), .sub(1'b0), .res(addr_b_s));

   // Sequencer FSM with registered step strobes and addresses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         phase_r   <= 1'b0;
         k_r       <= 5'd0;
         wp_snap_r <= '0;
         wr_addr   <= '0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         coef_idx  <= '0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         mac_sub   <= 1'b0;
         ctr_sel   <= 1'b0;
         out_vld   <= 1'b0;
         busy      <= 1'b0;
      end else if (sclr) begin
         state_r   <= ST_IDLE;
         phase_r   <= 1'b0;
         k_r       <= 5'd0;
         wp_snap_r <= '0;
         wr_addr   <= '0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         coef_idx  <= '0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         mac_sub   <= 1'b0;
         ctr_sel   <= 1'b0;
         out_vld   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (in_vld) phase_r <= ~phase_r;
         if (wr_en) wr_addr <= (wr_addr == ADDR_W'(DEPTH-1)) ? '0 : wr_addr + 6'd1;
         mac_en  <= 1'b0;
         mac_clr <= 1'b0;
         mac_sub <= 1'b0;
         ctr_sel <= 1'b0;
         out_vld <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_s) begin
                  state_r   <= ST_RUN;
                  wp_snap_r <= wr_addr;
                  k_r       <= 5'd0;
                  busy      <= 1'b1;
                  rd_addr_a <= addr_a_s;
                  rd_addr_b <= addr_b_s;
                  coef_idx  <= k_nxt_s;
                  mac_en    <= 1'b1;
                  mac_clr   <= 1'b1;
                  mac_sub   <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (k_r == 5'(NPAIR-1)) begin
                  state_r  <= ST_CTR;
                  coef_idx <= COEF_W'(CTR_IDX);
                  mac_en   <= 1'b1;
                  ctr_sel  <= 1'b1;
               end else begin
                  k_r       <= k_nxt_s;
                  rd_addr_a <= addr_a_s;
                  rd_addr_b <= addr_b_s;
                  coef_idx  <= k_nxt_s;
                  mac_en    <= 1'b1;
                  mac_sub   <= k_nxt_s[0];
               end
            end
            ST_CTR: begin
               state_r <= ST_DRAIN;
               k_r     <= 5'd0;
            end
            ST_DRAIN: begin
               if (k_r == 5'(MAC_LAT-1)) begin
                  state_r <= ST_DONE;
                  k_r     <= 5'd0;
                  out_vld <= 1'b1;
               end else begin
                  k_r <= k_r + 5'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun flag; a new overrun beats a simultaneous clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_err <= 1'b0;
      end else if (start_s && run_busy_s) begin
         ovf_err <= 1'b1;
      end else if (err_clr) begin
         ovf_err <= 1'b0;
      end else begin
         ovf_err <= ovf_err;
      end
   end
endmodule

// File: tb/tb_hb_mac_sched.sv
// Scoreboard bench for hb_mac_sched: a sample-level model predicts every MAC step
// and done pulse; a negedge monitor pops and compares whenever the DUT strobes.
module tb_hb_mac_sched;
   localparam int L   = 2;
   localparam int DEP = 38;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       sclr = 1'b0;
   logic       in_vld = 1'b0;
   logic       err_clr = 1'b0;
   logic       wr_en, ctr_en, mac_en, mac_clr, mac_sub, ctr_sel, out_vld, busy, ovf_err;
   logic [5:0] wr_addr, rd_addr_a, rd_addr_b;
   logic [4:0] coef_idx;

   hb_mac_sched #(.MAC_LAT(L)) dut (
      .clk(clk), .rstn(rstn), .sclr(sclr), .in_vld(in_vld), .err_clr(err_clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .ctr_en(ctr_en),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .coef_idx(coef_idx),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_sub(mac_sub), .ctr_sel(ctr_sel),
      .out_vld(out_vld), .busy(busy), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [21:0] expv;
      logic [21:0] mask;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: sample parity, write count, overrun flag, busy windows
   int ph_m, wa_m, ovf_m, busy_lo, busy_hi, run_hi;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, expv);
      end
   endtask

   task automatic flush(input int from);
      exp_t keep[$];
      foreach (sbq[i]) if (sbq[i].cyc < from) keep.push_back(sbq[i]);
      sbq = keep;
   endtask

   task automatic model_reset();
      ph_m = 0; wa_m = 0; ovf_m = 0; busy_lo = 0; busy_hi = -1; run_hi = -1;
   endtask

   // Expected activity of one accepted odd sample at cycle t0 with snapshot pointer wp
   task automatic push_seq(input int t0, input int wp);
      exp_t e;
      for (int k = 0; k < 19; k++) begin
         e.cyc  = t0 + 1 + k;
         e.expv = {1'b1, 1'b0, 5'(k), (k == 0), 1'(k % 2), 1'b0,
                   6'((wp - 1 - k + 2 * DEP) % DEP), 6'((wp + k) % DEP)};
         e.mask = '1;
         sbq.push_back(e);
      end
      e.cyc  = t0 + 20;
      e.expv = {1'b1, 1'b0, 5'd19, 1'b0, 1'b0, 1'b1, 12'd0};
      e.mask = {10'h3FF, 12'd0};
      sbq.push_back(e);
      e.cyc  = t0 + 21 + L;
      e.expv = {1'b0, 1'b1, 20'd0};
      e.mask = {2'b11, 20'd0};
      sbq.push_back(e);
   endtask

   // One clock of stimulus: check combinational/registered state, then advance the model
   task automatic step(input bit v, input bit ec, input bit sc);
      bit set;
      in_vld = v; err_clr = ec; sclr = sc;
      #1;
      chk("wr_en", wr_en, (v && ph_m == 0 && !sc));
      chk("ctr_en", ctr_en, (v && ph_m == 1 && !sc));
      chk("wr_addr", wr_addr, wa_m);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      chk("ovf_err", ovf_err, ovf_m);
      set = 0;
      if (sc) begin
         ph_m = 0; wa_m = 0;
         flush(cyc + 1);
         if (busy_hi > cyc) busy_hi = cyc;
         if (run_hi > cyc) run_hi = cyc;
      end else if (v) begin
         if (ph_m == 0) begin
            wa_m = (wa_m + 1) % DEP;
         end else if (cyc > run_hi) begin
            push_seq(cyc, wa_m);
            busy_lo = cyc + 1; busy_hi = cyc + 21 + L; run_hi = cyc + 20 + L;
         end else begin
            set = 1;
         end
         ph_m ^= 1;
      end
      if (set) ovf_m = 1;
      else if (ec) ovf_m = 0;
      @(posedge clk); #1;
      in_vld = 0; err_clr = 0; sclr = 0;
   endtask

   task automatic send(input int gap, input bit ec);
      repeat (gap - 1) step(0, 0, 0);
      step(1, ec, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0);
   endtask

   task automatic do_reset();
      rstn = 0;
      #1;
      chk("rst_outs", {wr_en, ctr_en, wr_addr, rd_addr_a, rd_addr_b, coef_idx, mac_en, mac_clr,
                       mac_sub, ctr_sel, out_vld, busy, ovf_err}, 64'd0);
      flush(cyc);
      model_reset();
      @(posedge clk); #1;
      rstn = 1;
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation, on its cycle
   always @(negedge clk) begin
      if (rstn) begin
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing cyc=%0d act=none exp=cyc%0d", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         if (mac_en || out_vld) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected cyc=%0d act=mac_en%0b/out_vld%0b exp=idle", cyc, mac_en, out_vld);
            end else begin
               mon_e = sbq.pop_front();
               chk("step_cyc", cyc, mon_e.cyc);
               chk("step", {mac_en, out_vld, coef_idx, mac_clr, mac_sub, ctr_sel, rd_addr_a, rd_addr_b}
                           & mon_e.mask, mon_e.expv & mon_e.mask);
            end
         end
      end
   end

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();
      idle(3);
      // Six even/odd pairs at 12-clock spacing; the last odd sees wp=6
      repeat (12) send(12, 0);
      idle(30);
      // Asynchronous reset in the middle of a sequence
      send(12, 0); send(12, 0);
      idle(8);
      do_reset();
      idle(3);
      // 37 even writes, odd at wp=37, then the pointer wraps to 0
      repeat (74) send(12, 0);
      send(12, 0);
      idle(30);
      // Overrun at 11-clock spacing, then clear the flag
      step(0, 0, 1);
      repeat (6) send(11, 0);
      idle(30);
      step(0, 1, 0);
      idle(3);
      // Soft clear at T0+10
      step(0, 0, 1);
      send(12, 0); send(12, 0);
      idle(9);
      step(0, 0, 1);
      idle(3);
      send(5, 0); send(12, 0);
      idle(30);
      // Odd sample lands exactly on the DONE cycle
      step(0, 0, 1);
      send(3, 0); send(3, 0); send(12, 0); send(11, 0);
      idle(30);
      // Randomized traffic with occasional soft clears and flag clears
      repeat (300) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2) step(1'($urandom_range(0, 1)), 0, 1);
         else send($urandom_range(1, 16), ($urandom_range(0, 9) == 0));
      end
      idle(40);
      chk("queue_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
